// File: rtl/memory_stage.sv
// memory_stage: MIPS MEM stage; registers EXE results, extracts load data from the data SRAM,
// holds read data across WB stalls and exposes a forwarding view to decode.
module memory_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exe_valid,
    input  logic [2:0]  exe_out_op,
    input  logic [4:0]  exe_dest,
    input  logic [31:0] exe_value,
    input  logic [31:0] exe_rt_value,
    input  logic [31:0] exe_pc,
    input  logic [31:0] exe_inst,
    output logic        mem_allowin,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    output logic        mem_valid,
    output logic [2:0]  mem_out_op,
    output logic [4:0]  mem_dest,
    output logic [31:0] mem_value,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_inst,
    output logic [4:0]  mem_fwd_dest,
    output logic        mem_is_load
);
    logic        valid_q, valid_d, fresh_q, fresh_d, hold_valid_q, hold_valid_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] value_q, value_d, rt_q, rt_d, pc_q, pc_d, inst_q, inst_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        take;
    logic [5:0]  opc;
    logic [1:0]  a;
    logic [4:0]  sh;
    logic [31:0] d, d_sh, lwl_v, lwr_v, load_v;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        is_load;

    assign mem_allowin = !valid_q || wb_allowin;
    assign take        = exe_valid && mem_allowin;

    always_comb begin
        valid_d     = mem_allowin ? exe_valid : valid_q;
        op_d        = take ? exe_out_op : op_q;
        dest_d      = take ? exe_dest : dest_q;
        value_d     = take ? exe_value : value_q;
        rt_d        = take ? exe_rt_value : rt_q;
        pc_d        = take ? exe_pc : pc_q;
        inst_d      = take ? exe_inst : inst_q;
        fresh_d     = take;
        // SRAM data is only valid on the fresh cycle, so capture it then if WB refuses it
        hold_valid_d = mem_allowin ? 1'b0 : (valid_q && fresh_q) ? 1'b1 : hold_valid_q;
        hold_data_d  = (valid_q && fresh_q && !wb_allowin) ? data_sram_rdata : hold_data_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q      <= 1'b0;
            op_q         <= '0;
            dest_q       <= '0;
            value_q      <= '0;
            rt_q         <= '0;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            fresh_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            op_q         <= op_d;
            dest_q       <= dest_d;
            value_q      <= value_d;
            rt_q         <= rt_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            fresh_q      <= fresh_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    always_comb begin
        opc    = inst_q[31:26];
        a      = value_q[1:0];
        sh     = {a, 3'b000};
        d      = hold_valid_q ? hold_data_q : data_sram_rdata;
        d_sh   = d >> sh;
        byte_v = d_sh[7:0];
        half_v = a[1] ? d[31:16] : d[15:0];
        // unaligned loads merge the shifted memory word with the untouched rt bytes
        lwl_v  = (d << (5'd24 - sh)) | (rt_q & (32'h00ffffff >> sh));
        lwr_v  = d_sh | (rt_q & ~(32'hffffffff >> sh));
        is_load = opc inside {6'b100000, 6'b100100, 6'b100001, 6'b100101,
                              6'b100011, 6'b100010, 6'b100110};
        load_v = (opc == 6'b100000) ? {{24{byte_v[7]}}, byte_v} :
                 (opc == 6'b100100) ? {24'b0, byte_v} :
                 (opc == 6'b100001) ? (a[0] ? 32'b0 : {{16{half_v[15]}}, half_v}) :
                 (opc == 6'b100101) ? (a[0] ? 32'b0 : {16'b0, half_v}) :
                 (opc == 6'b100011) ? d :
                 (opc == 6'b100010) ? lwl_v :
                 (opc == 6'b100110) ? lwr_v : value_q;
    end

    assign mem_valid    = valid_q;
    assign mem_out_op   = op_q;
    assign mem_dest     = dest_q;
    assign mem_value    = load_v;
    assign mem_pc       = pc_q;
    assign mem_inst     = inst_q;
    assign mem_fwd_dest = valid_q ? dest_q : 5'd0;
    assign mem_is_load  = valid_q && is_load;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vector table for load extraction plus stall/reset sequences.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        resetn, exe_valid, wb_allowin;
    logic [2:0]  exe_out_op;
    logic [4:0]  exe_dest;
    logic [31:0] exe_value, exe_rt_value, exe_pc, exe_inst, data_sram_rdata;
    logic        mem_allowin, mem_valid, mem_is_load;
    logic [2:0]  mem_out_op;
    logic [4:0]  mem_dest, mem_fwd_dest;
    logic [31:0] mem_value, mem_pc, mem_inst;
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .exe_out_op(exe_out_op),
        .exe_dest(exe_dest), .exe_value(exe_value), .exe_rt_value(exe_rt_value),
        .exe_pc(exe_pc), .exe_inst(exe_inst), .mem_allowin(mem_allowin),
        .data_sram_rdata(data_sram_rdata), .wb_allowin(wb_allowin), .mem_valid(mem_valid),
        .mem_out_op(mem_out_op), .mem_dest(mem_dest), .mem_value(mem_value), .mem_pc(mem_pc),
        .mem_inst(mem_inst), .mem_fwd_dest(mem_fwd_dest), .mem_is_load(mem_is_load)
    );

    typedef struct packed {
        logic [5:0]  opc;
        logic [31:0] value;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [31:0] exp;
        logic        ld;
    } vec_t;

    vec_t v[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [5:0] opc, input logic [31:0] value,
                         input logic [31:0] rt, input logic [31:0] pc, input logic [4:0] dest);
        exe_valid    = vld;
        exe_out_op   = opc[2:0];
        exe_dest     = dest;
        exe_value    = value;
        exe_rt_value = rt;
        exe_pc       = pc;
        exe_inst     = {opc, 20'h0, 6'b100001};
    endtask

    initial begin
        v[0]  = '{6'b100011, 32'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        v[1]  = '{6'b100000, 32'h103, 32'h0,        32'h80123456, 32'hFFFFFF80, 1'b1};
        v[2]  = '{6'b100100, 32'h103, 32'h0,        32'h80123456, 32'h00000080, 1'b1};
        v[3]  = '{6'b100001, 32'h102, 32'h0,        32'h80011234, 32'hFFFF8001, 1'b1};
        v[4]  = '{6'b100101, 32'h100, 32'h0,        32'h80019234, 32'h00009234, 1'b1};
        v[5]  = '{6'b100001, 32'h101, 32'h0,        32'h80019234, 32'h00000000, 1'b1};
        v[6]  = '{6'b100010, 32'h101, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344, 1'b1};
        v[7]  = '{6'b100110, 32'h102, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB, 1'b1};
        v[8]  = '{6'b100110, 32'h100, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD, 1'b1};
        v[9]  = '{6'b100010, 32'h100, 32'h11223344, 32'hAABBCCDD, 32'hDD223344, 1'b1};
        v[10] = '{6'b100110, 32'h103, 32'h11223344, 32'hAABBCCDD, 32'h112233AA, 1'b1};
        v[11] = '{6'b100000, 32'h100, 32'h0,        32'h80123456, 32'h00000056, 1'b1};
        v[12] = '{6'b000000, 32'h5,   32'h0,        32'h12345678, 32'h00000005, 1'b0};

        resetn = 1'b0;
        wb_allowin = 1'b1;
        data_sram_rdata = '0;
        drive(1'b0, 6'b0, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_pc", mem_pc, 32'hbfc00000);
        check("rst_op", {29'b0, mem_out_op}, 32'd0);
        check("rst_dest", {27'b0, mem_dest}, 32'd0);
        check("rst_allowin", {31'b0, mem_allowin}, 32'd1);
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(1'b1, v[i].opc, v[i].value, v[i].rt, 32'hbfc00100 + 32'(i * 4), 5'(i + 1));
            @(negedge clk);
            exe_valid = 1'b0;
            data_sram_rdata = v[i].rdata;
            #1;
            check($sformatf("v%0d_valid", i), {31'b0, mem_valid}, 32'd1);
            check($sformatf("v%0d_value", i), mem_value, v[i].exp);
            check($sformatf("v%0d_isload", i), {31'b0, mem_is_load}, {31'b0, v[i].ld});
            check($sformatf("v%0d_fwd", i), {27'b0, mem_fwd_dest}, 32'(i + 1));
            check($sformatf("v%0d_pc", i), mem_pc, 32'hbfc00100 + 32'(i * 4));
            @(negedge clk);
            check($sformatf("v%0d_drop_valid", i), {31'b0, mem_valid}, 32'd0);
            check($sformatf("v%0d_drop_fwd", i), {27'b0, mem_fwd_dest}, 32'd0);
            check($sformatf("v%0d_drop_ld", i), {31'b0, mem_is_load}, 32'd0);
        end

        // WB stall on the fresh cycle while EXE presents the next instruction
        drive(1'b1, 6'b100011, 32'h200, 32'h0, 32'hbfc00200, 5'd3);
        @(negedge clk);
        drive(1'b1, 6'b000000, 32'h77, 32'h0, 32'hbfc00204, 5'd4);
        wb_allowin = 1'b0;
        data_sram_rdata = 32'hCAFEF00D;
        #1;
        check("stall_fresh_value", mem_value, 32'hCAFEF00D);
        check("stall_fresh_allowin", {31'b0, mem_allowin}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            data_sram_rdata = (k == 1) ? 32'hFFFFFFFF : 32'h0;
            #1;
            check($sformatf("stall%0d_value", k), mem_value, 32'hCAFEF00D);
            check($sformatf("stall%0d_allowin", k), {31'b0, mem_allowin}, 32'd0);
            check($sformatf("stall%0d_pc", k), mem_pc, 32'hbfc00200);
        end
        @(negedge clk);
        wb_allowin = 1'b1;
        data_sram_rdata = 32'h0;
        #1;
        check("release_value", mem_value, 32'hCAFEF00D);
        check("release_allowin", {31'b0, mem_allowin}, 32'd1);
        @(negedge clk);
        exe_valid = 1'b0;
        #1;
        check("next_pc", mem_pc, 32'hbfc00204);
        check("next_value", mem_value, 32'h77);
        check("next_isload", {31'b0, mem_is_load}, 32'd0);

        // reset in the middle of a stall
        @(negedge clk);
        drive(1'b1, 6'b100011, 32'h300, 32'h0, 32'hbfc00300, 5'd5);
        @(negedge clk);
        exe_valid = 1'b0;
        wb_allowin = 1'b0;
        data_sram_rdata = 32'h12345678;
        @(negedge clk);
        check("prerst_hold", {31'b0, dut.hold_valid_q}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_valid", {31'b0, mem_valid}, 32'd0);
        check("midrst_pc", mem_pc, 32'hbfc00000);
        check("midrst_hold", {31'b0, dut.hold_valid_q}, 32'd0);
        check("midrst_allowin", {31'b0, mem_allowin}, 32'd1);
        resetn = 1'b1;
        wb_allowin = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, between the execute stage and writeback.
- Registers the EXE results and uses a valid/allowin handshake with EXE and WB.
- Extracts and extends load data from the synchronous data SRAM for LB/LBU/LH/LHU/LW/LWL/LWR, using the same little-endian byte lanes as the store path.
- Holds the SRAM read data when WB stalls, and provides a forwarding/hazard view to decode.

Parameters:
- RESET_PC, 32'hbfc00000, reset value of mem_pc.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- exe_valid  in  1  EXE holds a valid instruction
- exe_out_op  in  3  control op from EXE
- exe_dest  in  5  destination register, 0 if none
- exe_value  in  32  ALU result / memory address
- exe_rt_value  in  32  old rt value, merged by LWL/LWR
- exe_pc  in  32  EXE pc
- exe_inst  in  32  EXE instruction
- mem_allowin  out  1  MEM accepts EXE this cycle
- data_sram_rdata  in  32  SRAM read data, valid one cycle after address issue
- wb_allowin  in  1  WB accepts MEM this cycle
- mem_valid  out  1  MEM holds a valid instruction
- mem_out_op  out  3  registered op
- mem_dest  out  5  registered dest
- mem_value  out  32  final result to WB (load data or passthrough)
- mem_pc  out  32  registered pc
- mem_inst  out  32  registered instruction
- mem_fwd_dest  out  5  mem_dest when mem_valid, else 0
- mem_is_load  out  1  mem_valid and the instruction is a load

Behaviour:
- Reset (resetn=0 at posedge clk):
  - mem_valid=0, mem_out_op=0, mem_dest=0, value/rt/inst regs=0, mem_pc=RESET_PC.
  - hold_valid=0, fresh=0.
- Handshake:
  - mem_allowin = !mem_valid | wb_allowin (combinational).
  - On posedge with mem_allowin=1: mem_valid<=exe_valid.
  - If exe_valid, capture op, dest, value, rt_value, pc, inst. If not exe_valid, the payload regs keep their old contents.
  - With mem_allowin=0, all payload regs hold.
- Fresh flag:
  - fresh<=1 on a transfer (exe_valid & mem_allowin); otherwise fresh<=0.
  - data_sram_rdata is valid only while fresh=1.
- Read-data hold:
  - If mem_valid & fresh & !wb_allowin: hold_data<=data_sram_rdata, hold_valid<=1.
  - hold_valid clears whenever mem_allowin=1.
  - rdata_eff = hold_valid ? hold_data : data_sram_rdata.
- Load decode on mem_inst[31:26]:
  - LB 100000, LBU 100100, LH 100001, LHU 100101, LW 100011, LWL 100010, LWR 100110.
  - a = mem_value_reg[1:0].
- Load results:
  - LB/LBU: byte rdata_eff[8a+7:8a]; LB sign-extends, LBU zero-extends.
  - LH/LHU: halfword at a=0 → [15:0], a=2 → [31:16]; LH sign-extends, LHU zero-extends. a odd → result 0 (address error is handled elsewhere).
  - LW: rdata_eff.
  - LWL, r=rt_reg, d=rdata_eff:
    - a=0 → {d[7:0], r[23:0]}
    - a=1 → {d[15:0], r[15:0]}
    - a=2 → {d[23:0], r[7:0]}
    - a=3 → d
  - LWR, r=rt_reg, d=rdata_eff:
    - a=0 → d
    - a=1 → {r[31:24], d[31:8]}
    - a=2 → {r[31:16], d[31:16]}
    - a=3 → {r[31:8], d[31:24]}
  - Non-load: mem_value = mem_value_reg.
- Hazard outputs:
  - mem_fwd_dest=0 and mem_is_load=0 whenever mem_valid=0.
- Simultaneous events:
  - WB stalls in the same cycle EXE presents: MEM holds, EXE is not accepted, and hold_data is captured if fresh.
  - Reset mid-stall: drops the instruction and clears hold_valid.
- Latency: one cycle from EXE accept to mem_valid. Load result is combinational from rdata_eff in the MEM cycle.

Test Plan:
- LW, exe_value=0x100, rdata=0xDEADBEEF, wb_allowin=1 → next cycle mem_valid=1, mem_value=0xDEADBEEF, mem_is_load=1.
- LB a=3, rdata=0x80123456 → mem_value=0xFFFFFF80. LBU same → 0x00000080. LH a=2, rdata=0x8001xxxx → 0xFFFF8001.
- LWL a=1, rt=0x11223344, rdata=0xAABBCCDD → 0xCCDD3344. LWR a=2, same inputs → 0x1122AABB. LWR a=0 → 0xAABBCCDD.
- LW with rdata=0xCAFEF00D on the fresh cycle, wb_allowin=0 for 3 cycles while rdata toggles to 0x0 → mem_value stays 0xCAFEF00D, mem_allowin=0, and the value is released once wb_allowin=1.
- ADDU passthrough exe_value=0x5, dest=8; then exe_valid=0 → mem_valid=0, mem_fwd_dest=0, mem_is_load=0.
- resetn=0 during a stall → mem_valid=0, mem_pc=0xbfc00000, hold_valid=0, mem_allowin=1.
